// File: rtl/mul_pkg.sv
// Shared types and widths for the sequential 64x64 multiplier.
package mul_pkg;

    localparam int unsigned MUL_W  = 64;
    localparam int unsigned PROD_W = 128;
    localparam int unsigned CNT_W  = 7;

    localparam logic [CNT_W-1:0] CNT_LAST = 7'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla64.sv
// 64-bit carry look-ahead adder: 4-bit lookahead groups, group carries chained.
module cla64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        ci_i,
    output logic [63:0] sum_c_o,
    output logic        co_c_o
);

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic        grp_c;
    logic [3:0]  gg;
    logic [3:0]  pp;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Per-bit carries from each group's generate/propagate and its carry-in.
    always_comb begin
        c     = '0;
        gg    = '0;
        pp    = '0;
        grp_c = ci_i;
        for (int k = 0; k < 16; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            c[4*k]     = grp_c;
            c[4*k + 1] = gg[0] | (pp[0] & grp_c);
            c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_c);
            c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                       | (pp[2] & pp[1] & pp[0] & grp_c);
            grp_c      = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & grp_c);
        end
    end

    assign sum_c_o = p ^ c;
    assign co_c_o  = grp_c;

endmodule

// File: rtl/mul64_seq.sv
// Sequential unsigned 64x64->128 shift-and-add multiplier, one cla64 step per cycle.
// Optional MUL_ZERO_SKIP_EN: zero operand at start goes straight to DONE with product 0.
module mul64_seq
    import mul_pkg::*;
#(
    parameter int unsigned W = MUL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic [W-1:0]     multiplicand,
    input  logic [W-1:0]     multiplier,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             done
);

    state_e              state_q, state_d;
    logic [W-1:0]        mcand_q, mcand_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept_c;
    logic                zero_op_c;
    logic [W-1:0]        add_sum_c;
    logic                add_co_c;
    logic [W:0]          step_hi_c;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op_c = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op_c = 1'b0;
`endif

    assign accept_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    cla64 U0_cla64 (
        .a_i     (prod_q[PROD_W-1:W]),
        .b_i     (mcand_q),
        .ci_i    (1'b0),
        .sum_c_o (add_sum_c),
        .co_c_o  (add_co_c)
    );

    // Add the multiplicand into the upper half only when the current multiplier bit is set.
    assign step_hi_c = prod_q[0] ? {add_co_c, add_sum_c} : {1'b0, prod_q[PROD_W-1:W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = zero_op_c ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        busy_d = (state_d == ST_EXEC);
        done_d = (state_d == ST_DONE);
    end

    // Operand capture, shift-add step and step counter.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (clear) begin
            prod_d = '0;
            cnt_d  = '0;
        end else if (accept_c) begin
            mcand_d = multiplicand;
            prod_d  = zero_op_c ? '0 : {{W{1'b0}}, multiplier};
            cnt_d   = '0;
        end else if (state_q == ST_EXEC) begin
            prod_d = {step_hi_c, prod_q[W-1:1]};
            cnt_d  = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result = prod_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mul64_seq.sv
// Self-checking bench for mul64_seq: scoreboard of expected products, latency and control checks.
module tb_mul64_seq;

`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT  = 0;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 64;
    localparam int ZBUSY = 64;
`endif
    localparam int LAT   = 64;
    localparam int BOUND = 200;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [63:0]  a = '0;
    logic [63:0]  b = '0;
    logic [127:0] result;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    mul64_seq #(.W(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .clear        (clear),
        .multiplicand (a),
        .multiplier   (b),
        .result       (result),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge and record the reference product.
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        exp_q.push_back(128'(ia) * 128'(ib));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded) and busy samples along the way.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (result !== 128'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_mult(input string name, input logic [63:0] ia, input logic [63:0] ib,
                             input int exp_lat, input int exp_busy);
        int lat, bc, b0;
        logic [127:0] exp;
        issue(ia, ib);
        b0 = busy ? 1 : 0;
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        checks++; if (b0 + bc !== exp_busy) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, b0 + bc, exp_busy); end
        checks++; if (result !== exp) begin errors++; $display("FAIL %s_result got %h want %h", name, result, exp); end
    endtask

    task automatic test_ignore_start();
        int lat, bc, busy_cnt;
        logic [127:0] exp;
        issue(64'd20, 64'd21);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        a = 64'd7;
        b = 64'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy) busy_cnt++;
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++; if (10 + lat !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", 10 + lat, LAT); end
        checks++; if (busy_cnt + bc !== LAT) begin errors++; $display("FAIL ignore_busy_cycles got %0d want %0d", busy_cnt + bc, LAT); end
        checks++; if (result !== exp) begin errors++; $display("FAIL ignore_result got %h want %h", result, exp); end
        checks++; if (exp !== 128'd420) begin errors++; $display("FAIL ignore_model got %0d want 420", exp); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [127:0] exp;
        issue(64'd2, 64'd3);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart busy=%b done=%b want 1/0", busy, done); end
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++; if (result !== exp) begin errors++; $display("FAIL b2b_result got %h want %h", result, exp); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        logic [127:0] exp;
        issue(64'hDEAD_BEEF, 64'h1234_5678);
        exp = exp_q.pop_front();
        for (int i = 0; i < 29; i++) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags busy=%b done=%b want 0/0", busy, done); end
        checks++; if (result !== 128'h0) begin errors++; $display("FAIL midreset_result got %h want 0 (discarded %h)", result, exp); end
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", done_seen); end
    endtask

    task automatic test_clear_start();
        int active;
        test_mult("pre_clear", 64'd4, 64'd5, LAT, LAT);
        @(negedge clk);
        a = 64'd9;
        b = 64'd9;
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_flags busy=%b done=%b want 0/0", busy, done); end
        checks++; if (result !== 128'h0) begin errors++; $display("FAIL clear_result got %h want 0", result); end
        active = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || busy) active++;
        end
        checks++; if (active !== 0) begin errors++; $display("FAIL clear_stays_idle got %0d active cycles want 0", active); end
    endtask

    initial begin
        test_reset();
        test_mult("basic_3x5", 64'd3, 64'd5, LAT, LAT);
        checks++; if (result !== 128'h0F) begin errors++; $display("FAIL basic_literal got %h want 0f", result); end
        test_mult("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, LAT, LAT);
        checks++; if (result !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin errors++; $display("FAIL max_literal got %h", result); end
        test_mult("zero_a", 64'd0, 64'd7, ZLAT, ZBUSY);
        test_mult("zero_b", 64'h1234_5678_9ABC_DEF0, 64'd0, ZLAT, ZBUSY);
        for (int i = 0; i < 4; i++) begin
            test_mult("random", {$urandom, $urandom}, {$urandom, $urandom}, LAT, LAT);
        end
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_clear_start();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
